// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared constants and FSM state type for the SPI register peripheral
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam logic [4:0] CNT_SAT = 5'd17;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        COMMIT
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage input synchroniser with rise/fall pulse detection
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            last_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~last_q;
    assign fall_o  = ~level_o & last_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 write-only frame decoder driving five 8-bit control registers
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr
);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic copi_level, copi_rise_unused, copi_fall_unused;
    logic ncs_level, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .level_o(copi_level), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .level_o(ncs_level), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    spi_state_e state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [7:0]            out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
    logic [6:0]            wr_addr_q;
    logic                  wr_strobe_q;

    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       commit_ok;

    assign frame_addr = shift_q[14:8];
    assign frame_data = shift_q[7:0];
    assign commit_ok  = (state_q == COMMIT) && (cnt_q == 5'(FRAME_BITS))
                        && shift_q[15] && (frame_addr <= MAX_ADDR);

    // ncs rise is checked before sclk rise so a coincident clock edge is dropped
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_IDLE: if (ncs_level) state_d = IDLE;
            IDLE: begin
                if (ncs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_level};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            pwm_lo_q    <= '0;
            pwm_hi_q    <= '0;
            duty_q      <= '0;
            wr_addr_q   <= '0;
            wr_strobe_q <= 1'b0;
        end else begin
            wr_strobe_q <= commit_ok;
            if (commit_ok) begin
                wr_addr_q <= frame_addr;
                case (frame_addr)
                    ADDR_EN_OUT_7_0:  out_lo_q <= frame_data;
                    ADDR_EN_OUT_15_8: out_hi_q <= frame_data;
                    ADDR_EN_PWM_7_0:  pwm_lo_q <= frame_data;
                    ADDR_EN_PWM_15_8: pwm_hi_q <= frame_data;
                    ADDR_PWM_DUTY:    duty_q   <= frame_data;
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_addr         = wr_addr_q;
    assign wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - directed and randomised-phase bench for spi_reg_peripheral
module tb_spi_reg_peripheral;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;
    logic [6:0] wr_addr;

    spi_reg_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] bits;
        int          nbits;
        logic        wr;
        int          idx;
        logic [7:0]  data;
        string       name;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] mdl[5];
    logic [7:0] dut_regs[5];
    int         nvec = 0;
    int         nfail = 0;
    int         strobe_cnt = 0;
    int         s0;

    assign dut_regs[0] = en_reg_out_7_0;
    assign dut_regs[1] = en_reg_out_15_8;
    assign dut_regs[2] = en_reg_pwm_7_0;
    assign dut_regs[3] = en_reg_pwm_15_8;
    assign dut_regs[4] = pwm_duty_cycle;

    always @(negedge clk) if (wr_strobe) strobe_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s reg%0d", tag, i), {24'h0, dut_regs[i]}, {24'h0, mdl[i]});
    endtask

    // leaves ncs low and sclk low after the last bit
    task automatic send_bits(input logic [16:0] bits, input int nbits, input int ph_min, input int ph_max);
        ncs = 1'b0;
        #($urandom_range(ph_max, ph_min));
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            #($urandom_range(ph_max, ph_min));
            sclk = 1'b1;
            #($urandom_range(ph_max, ph_min));
            sclk = 1'b0;
        end
        #($urandom_range(ph_max, ph_min));
    endtask

    task automatic send_frame(input logic [16:0] bits, input int nbits, input int ph_min, input int ph_max);
        send_bits(bits, nbits, ph_min, ph_max);
        ncs = 1'b1;
        #60;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{17'h080F0, 16, 1'b1, 0, 8'hF0, "w00_F0"};
        tbl[1] = '{17'h08480, 16, 1'b1, 4, 8'h80, "w04_80"};
        tbl[2] = '{17'h083AA, 16, 1'b1, 3, 8'hAA, "w03_AA"};
        tbl[3] = '{17'h08555, 16, 1'b0, 0, 8'h00, "addr05"};
        tbl[4] = '{17'h00055, 16, 1'b0, 0, 8'h00, "read00"};
        tbl[5] = '{17'h04008, 15, 1'b0, 0, 8'h00, "short15"};
        tbl[6] = '{17'h10023, 17, 1'b0, 0, 8'h00, "long17"};
        tbl[7] = '{17'h08101, 16, 1'b1, 1, 8'h01, "w01_01"};
        tbl[8] = '{17'h08233, 16, 1'b1, 2, 8'h33, "w02_33"};
        tbl[9] = '{17'h084FF, 16, 1'b1, 4, 8'hFF, "w04_FF"};
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;

        #23 rst_n = 1'b1;

        // reset state and 1000 quiet cycles with ncs high
        s0 = strobe_cnt;
        repeat (1000) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset wr_addr", {25'h0, wr_addr}, 32'h0);
        check("idle strobes", strobe_cnt - s0, 0);

        // commit latency: register updates on the 4th edge after ncs rise is sampled
        send_bits(17'h080F0, 16, 40, 40);
        @(posedge clk);
        #1 ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lat edge3 reg0", {24'h0, en_reg_out_7_0}, 32'h00);
        check("lat edge3 strobe", {31'h0, wr_strobe}, 32'h0);
        @(posedge clk);
        #1;
        check("lat edge4 reg0", {24'h0, en_reg_out_7_0}, 32'hF0);
        check("lat edge4 strobe", {31'h0, wr_strobe}, 32'h1);
        check("lat wr_addr", {25'h0, wr_addr}, 32'h00);
        @(posedge clk);
        #1;
        check("lat edge5 strobe", {31'h0, wr_strobe}, 32'h0);
        mdl[0] = 8'hF0;
        check_regs("lat");
        #60;

        // table vectors at SCLK = clk/8, ncs gap of 60 ns between frames
        for (int v = 0; v < 10; v++) begin
            s0 = strobe_cnt;
            send_frame(tbl[v].bits, tbl[v].nbits, 40, 40);
            if (tbl[v].wr) begin
                mdl[tbl[v].idx] = tbl[v].data;
                check({tbl[v].name, " wr_addr"}, {25'h0, wr_addr}, tbl[v].idx);
            end
            check({tbl[v].name, " strobes"}, strobe_cnt - s0, {31'h0, tbl[v].wr});
            check_regs(tbl[v].name);
        end

        // reset in the middle of a frame with ncs held low
        s0 = strobe_cnt;
        send_bits(17'h00081, 8, 40, 40);
        #17 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
        #40 rst_n = 1'b1;
        send_bits(17'h000FF, 8, 40, 40);
        ncs = 1'b1;
        #80;
        check("midrst strobes", strobe_cnt - s0, 0);
        check_regs("midrst");
        s0 = strobe_cnt;
        send_frame(17'h081FF, 16, 40, 40);
        mdl[1] = 8'hFF;
        check("post-rst strobes", strobe_cnt - s0, 1);
        check_regs("post-rst");

        // random clock phase at minimum SCLK width against a reference model
        s0 = 0;
        for (int f = 0; f < 200; f++) begin
            logic       rw;
            logic [6:0] a;
            logic [7:0] d;
            int         exp_cnt;
            rw = ($urandom_range(3, 0) != 0);
            a  = 7'($urandom_range(7, 0));
            d  = 8'($urandom);
            exp_cnt = strobe_cnt;
            #($urandom_range(9, 0));
            send_bits({1'b0, rw, a, d}, 16, 31, 39);
            ncs = 1'b1;
            #($urandom_range(70, 55));
            if (rw && a <= 7'h04) begin
                mdl[a[2:0]] = d;
                exp_cnt++;
            end
            check($sformatf("rand%0d strobes", f), strobe_cnt, exp_cnt);
            check_regs($sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
